// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared pointer helpers and parameter limits for the async FIFO controllers.
package async_fifo_pkg;
  localparam int ASIZE_MIN = 2;
  localparam int ASIZE_MAX = 12;
  localparam int PTR_MAX = ASIZE_MAX + 1;
  function automatic bit asize_ok(input int a);
    return a >= ASIZE_MIN && a <= ASIZE_MAX;
  endfunction
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Narrower pointers are zero-extended, so the upper prefix bits stay zero.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b = '0;
    for (int i = 0; i < PTR_MAX; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary conversion (XOR prefix from the MSB down).
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end
endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-side pointer, RAM write strobe and full/level flags of the async FIFO.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ASIZE = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic             src_clk,
  input  logic             src_rst,
  input  logic             wr_en,
  input  logic [ASIZE:0]   rd_ptr_sync,
  output logic             mem_we,
  output logic [ASIZE-1:0] wr_addr,
  output logic [ASIZE:0]   wr_ptr_gray,
  output logic             wr_full,
  output logic             wr_almost_full,
  output logic [ASIZE:0]   wr_level,
  output logic             wr_overflow
);
  if (!asize_ok(ASIZE)) begin : g_asize_err
    $error("async_fifo_wr_ctrl: ASIZE out of range");
  end
  localparam logic [ASIZE:0] AF_TH = (ASIZE+1)'((2**ASIZE) - AFULL_MARGIN);
  logic [ASIZE:0] wr_bin, bin_next, gray_next, rd_bin, level_next;
  logic push, full_next;
  gray2bin_conv #(.W(ASIZE+1)) u_rd_g2b (.gray(rd_ptr_sync), .bin(rd_bin));
  // Registered full gates the push, so a write while full is rejected even as the reader frees space.
  assign push = wr_en & ~wr_full;
  assign mem_we = push & ~src_rst;
  assign wr_addr = wr_bin[ASIZE-1:0];
  assign bin_next = wr_bin + (ASIZE+1)'(push);
  assign gray_next = bin_next ^ (bin_next >> 1);
  assign full_next = gray_next == {~rd_ptr_sync[ASIZE:ASIZE-1], rd_ptr_sync[ASIZE-2:0]};
  assign level_next = bin_next - rd_bin;
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      wr_bin <= '0;
      wr_ptr_gray <= '0;
      wr_full <= 1'b0;
      wr_almost_full <= 1'b0;
      wr_level <= '0;
      wr_overflow <= 1'b0;
    end else begin
      wr_bin <= bin_next;
      wr_ptr_gray <= gray_next;
      wr_full <= full_next;
      wr_almost_full <= level_next >= AF_TH;
      wr_level <= level_next;
      wr_overflow <= wr_overflow | (wr_en & wr_full);
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb_async_fifo_wr_ctrl: directed plan plus random traffic against a write/read-count reference model.
module tb_async_fifo_wr_ctrl;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  logic src_clk = 1'b0;
  logic src_rst = 1'b1;
  logic wr_en = 1'b0;
  logic [ASIZE:0] rd_ptr_sync = '0;
  logic mem_we, wr_full, wr_almost_full, wr_overflow;
  logic [ASIZE-1:0] wr_addr;
  logic [ASIZE:0] wr_ptr_gray, wr_level;
  int errors = 0;
  int checks = 0;
  int wcnt = 0;
  int rcnt = 0;
  bit m_full = 0;
  bit m_ovf = 0;
  int m_level = 0;

  async_fifo_wr_ctrl #(.ASIZE(ASIZE), .AFULL_MARGIN(2)) dut (
    .src_clk(src_clk), .src_rst(src_rst), .wr_en(wr_en), .rd_ptr_sync(rd_ptr_sync),
    .mem_we(mem_we), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray), .wr_full(wr_full),
    .wr_almost_full(wr_almost_full), .wr_level(wr_level), .wr_overflow(wr_overflow)
  );

  always #5 src_clk = ~src_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray_of(input int n);
    int m;
    m = n % 32;
    return 5'(m ^ (m >> 1));
  endfunction

  // One clock: drive inputs, check the write strobe, advance the model, check registered outputs.
  task automatic tick(input bit we, input int rc, input bit rst);
    wr_en = we;
    rcnt = rc;
    rd_ptr_sync = gray_of(rc);
    src_rst = rst;
    #1;
    chk("mem_we", 32'(mem_we), 32'(we && !m_full && !rst));
    @(posedge src_clk);
    if (rst) begin
      wcnt = 0;
      m_full = 0;
      m_ovf = 0;
      m_level = 0;
    end else begin
      if (we && m_full) m_ovf = 1;
      if (we && !m_full) wcnt++;
      m_level = wcnt - rc;
      m_full = m_level == DEPTH;
    end
    #1;
    chk("wr_addr", 32'(wr_addr), 32'(wcnt % DEPTH));
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray_of(wcnt)));
    chk("wr_full", 32'(wr_full), 32'(m_full));
    chk("wr_almost_full", 32'(wr_almost_full), 32'(!rst && m_level >= DEPTH - 2));
    chk("wr_level", 32'(wr_level), 32'(m_level));
    chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
  endtask

  initial begin
    tick(0, 0, 1);
    tick(0, 0, 1);
    for (int i = 0; i < 16; i++) tick(1, 0, 0);
    chk("p1_gray_end", 32'(wr_ptr_gray), 32'h18);
    chk("p1_level16", 32'(wr_level), 32'd16);
    chk("p1_full", 32'(wr_full), 32'd1);
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    for (int i = 0; i < 2; i++) tick(0, 0, 0);
    chk("p2_gray_hold", 32'(wr_ptr_gray), 32'h18);
    chk("p2_ovf_sticky", 32'(wr_overflow), 32'd1);
    tick(1, 1, 0);
    chk("p4_full_clear", 32'(wr_full), 32'd0);
    chk("p4_level15", 32'(wr_level), 32'd15);
    tick(1, 1, 0);
    chk("p4_refill", 32'(wr_level), 32'd16);
    tick(0, 0, 1);
    for (int i = 0; i < 13; i++) tick(1, 0, 0);
    chk("p3_af_13", 32'(wr_almost_full), 32'd0);
    chk("p3_level13", 32'(wr_level), 32'd13);
    tick(1, 0, 0);
    chk("p3_af_14", 32'(wr_almost_full), 32'd1);
    tick(0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      tick(1, (wcnt >= 3) ? wcnt - 3 : 0, 0);
      if (wcnt >= 4) chk("p5_level4", 32'(wr_level), 32'd4);
    end
    tick(1, rcnt, 1);
    chk("p6_gray0", 32'(wr_ptr_gray), 32'd0);
    tick(1, 0, 0);
    chk("p6_resume", 32'(wr_addr), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      int rc;
      bit rst;
      rst = $urandom_range(0, 199) == 0;
      rc = rcnt;
      if (rst) rc = 0;
      else if (rc < wcnt && $urandom_range(0, 2) != 0) rc++;
      tick($urandom_range(0, 3) != 0, rc, rst);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
